// File: rtl/rshift_pkg.sv
// Shared widths and the request record carried through the right-shift queue.
package rshift_pkg;
  localparam int DATA_W  = 8;
  localparam int SHIFT_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHIFT_W-1:0] bits;
  } rshift_req_t;
endpackage

// File: rtl/rshift_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; head is read combinationally.
// Pushes while full and pops while empty are ignored; the caller gates them with full/empty.
module rshift_fifo #(
  parameter  int width = 11,
  parameter  int depth = 4,
  localparam int aw    = $clog2(depth),
  localparam int cw    = aw + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic [cw-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam logic [cw-1:0] max_count = cw'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == max_count);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rshifter.sv
// Combinational logical right barrel shifter, zero fill.
// Zero latency; no handshake, the result follows the inputs.
module rshifter #(
  parameter int data_width = 8,
  parameter int shift_len  = 3
) (
  input  logic [data_width-1:0] data,
  input  logic [shift_len-1:0]  bits,
  output logic [data_width-1:0] result
);
  logic [data_width-1:0] stage [shift_len+1];

  assign stage[0] = data;

  // Stage i shifts by 2**i when bit i of the amount is set.
  for (genvar i = 0; i < shift_len; i++) begin : g_stage
    assign stage[i+1] = bits[i] ? (stage[i] >> (2**i)) : stage[i];
  end

  assign result = stage[shift_len];
endmodule

// File: rtl/rshift_queue.sv
// Queued front end for rshifter: FIFO of requests, shift on the head, registered result + sticky.
// One cycle from acceptance to out_valid; in_ready drops only when the FIFO is full (depth + 1 in flight).
module rshift_queue
  import rshift_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int shift_len  = SHIFT_W,
  parameter int depth      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic [shift_len-1:0]  in_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_sticky
);
  localparam int cw = $clog2(depth) + 1;

  rshift_req_t       wr_req;
  rshift_req_t       head_req;
  logic [cw-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sticky;

  // in_ready comes from registered occupancy only, so out_ready never reaches it.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);

  assign wr_req.data = in_data;
  assign wr_req.bits = in_bits;

  rshift_fifo #(
    .width ($bits(rshift_req_t)),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_req),
    .pop       (pop),
    .head      (head_req),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  rshifter #(
    .data_width (DATA_W),
    .shift_len  (SHIFT_W)
  ) u_shift (
    .data   (head_req.data),
    .bits   (head_req.bits),
    .result (shifted)
  );

  // Low in_bits bits of the operand are exactly the ones that fall off the end.
  assign mask   = (DATA_W'(1) << head_req.bits) - DATA_W'(1);
  assign sticky = |(head_req.data & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_data   <= shifted;
      out_sticky <= sticky;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= cw'(depth));
  a_out_stable:  assert property (@(posedge clk) disable iff (rst)
                   (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sticky)));
endmodule

// File: tb/tb_rshift_queue.sv
// Bench for rshift_queue: vector table, scoreboard monitor, and hand-written backpressure/reset sequences.
module tb_rshift_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sticky;

  always #5 clk = ~clk;

  rshift_queue #(.data_width(8), .shift_len(3), .depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bits    (in_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sticky;
  } res_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] bits;
    logic [7:0] exp_data;
    logic       exp_sticky;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  res_t sb [$];
  res_t sb_head;
  vec_t vecs [8];
  logic [7:0] bp_d [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: sticky is set when shifting back left does not restore the operand.
  function automatic res_t model(input logic [7:0] d, input logic [2:0] b);
    res_t       r;
    logic [7:0] q;
    q        = d >> b;
    r.data   = q;
    r.sticky = ((q << b) != d);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && c < 60) begin
      tick();
      c++;
    end
    chk(name, 32'(sb.size()), 0);
  endtask

  // Scoreboard: record on accepted input, compare on accepted output.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_has_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          sb_head = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(sb_head.data));
          chk("sb_sticky", 32'(out_sticky), 32'(sb_head.sticky));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, in_bits));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int sent;
    int cyc;
    int stale;
    logic acc_now;

    vecs[0] = '{8'hB5, 3'd3, 8'h16, 1'b1};
    vecs[1] = '{8'hFF, 3'd0, 8'hFF, 1'b0};
    vecs[2] = '{8'h80, 3'd7, 8'h01, 1'b0};
    vecs[3] = '{8'h81, 3'd7, 8'h01, 1'b1};
    vecs[4] = '{8'h01, 3'd1, 8'h00, 1'b1};
    vecs[5] = '{8'hF0, 3'd4, 8'h0F, 1'b0};
    vecs[6] = '{8'h0F, 3'd4, 8'h00, 1'b1};
    vecs[7] = '{8'hAA, 3'd5, 8'h05, 1'b1};
    bp_d = '{8'h9C, 8'h47, 8'hE1, 8'h3A, 8'h55, 8'h0F};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bits = '0; out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sticky", 32'(out_sticky), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Single requests through an idle queue: latency and corner shifts.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b1; in_data = vecs[i].data; in_bits = vecs[i].bits;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_not_early", i), 32'(out_valid), 0);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_sticky", i), 32'(out_sticky), 32'(vecs[i].exp_sticky));
    end

    // Backpressure: six back-to-back offers, only depth + 1 fit.
    tick();
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = bp_d[i]; in_bits = 3'(i + 1);
      @(negedge clk);
      if (in_ready) acc++;
      if (i == 5) chk("bp_in_ready_full", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 'h4E);
      chk("bp_hold_sticky", 32'(out_sticky), 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(out_valid), 1);
      tick();
    end
    @(negedge clk);
    chk("bp_drain_done", 32'(out_valid), 0);
    #1;
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Full FIFO with push and pop offered together: push refused once, then taken.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h3C + 8'(i * 17); in_bits = 3'(i + 2);
      @(negedge clk);
      chk("fs_fill_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b1; in_data = 8'hD7; in_bits = 3'd2; out_ready = 1'b1;
    @(negedge clk);
    chk("fs_push_rejected", 32'(in_ready), 0);
    tick();
    @(negedge clk);
    chk("fs_push_retry", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    drain("fs_drain");

    // Random stream with a flapping consumer.
    in_valid = 1'b1; in_data = 8'($urandom); in_bits = 3'($urandom_range(0, 7));
    sent = 0; cyc = 0;
    while (sent < 16 && cyc < 2000) begin
      @(negedge clk);
      acc_now = in_ready;
      tick();
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (acc_now) begin
        sent++;
        in_data = 8'($urandom);
        in_bits = 3'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 16);
    drain("stream_drain");

    // Reset with a full output register and three queued entries.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i); in_bits = 3'(i);
      @(negedge clk);
      chk("mid_fill_ready", 32'(in_ready), 1);
      tick();
    end
    rst = 1'b1; in_data = 8'hEE; in_bits = 3'd1;
    @(negedge clk);
    chk("mid_pre_out_valid", 32'(out_valid), 1);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_post_out_valid", 32'(out_valid), 0);
    chk("mid_post_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 0);

    tick();
    in_valid = 1'b1; in_data = 8'hB5; in_bits = 3'd3;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_after_valid", 32'(out_valid), 1);
    chk("mid_after_data", 32'(out_data), 'h16);
    chk("mid_after_sticky", 32'(out_sticky), 1);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rshift_queue.md
# rshift_queue

Buffered, handshaked front end for the team's 8-bit logical right barrel shifter. Accepts (operand, shift amount) requests on a valid/ready port, queues them in a small FIFO, shifts the head entry through the combinational `rshifter` datapath, and presents the registered result plus a sticky (shifted-out-bits) flag on a valid/ready output. It sits between the command source and result consumers. It decouples both from the purely combinational shifter and gives one registered boundary.

## Interface
- `data_width`, 8: operand/result width; fixed at 8 to match `rshifter`.
- `shift_len`, 3: shift-amount width.
- `depth`, 4: FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: request will be accepted this cycle.
- `in_data` input `data_width`: operand.
- `in_bits` input `shift_len`: shift amount, 0..7.
- `out_valid` output 1: result register holds a result.
- `out_ready` input 1: consumer takes result this cycle.
- `out_data` output `data_width`: `in_data >> in_bits`, zero-filled.
- `out_sticky` output 1: OR of the `in_bits` low bits of `in_data` that were shifted out.

## Operation
- Push: `in_valid && in_ready` writes {`in_data`, `in_bits`} at the write pointer. `in_ready = (count < depth)`; there is no pass-through when full.
- Pop: `pop = (count != 0) && (!out_valid || out_ready)`. On pop, the head entry's shifted result and sticky are loaded into the output register, and `out_valid` is set.
- If `out_valid && out_ready && !pop`, `out_valid` clears. `out_data` and `out_sticky` hold their last values.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_sticky` must not change.
- Sticky: `out_sticky = |(in_data & ((1 << in_bits) - 1))`. It is computed from the FIFO head alongside the shift. `in_bits = 0` gives 0.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`. `count` is `$clog2(depth)+1` bits.
- Simultaneous push and pop: `count` is unchanged, both pointers advance. A push while the FIFO is empty and a pop in the same cycle cannot occur, because the entry is not yet in the FIFO.
- Ordering: results leave strictly in acceptance order. No request is dropped or duplicated.

## Timing
- Reset (synchronous): `count`, `wr_ptr`, `rd_ptr`, `out_valid`, `out_data` and `out_sticky` are all 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Reset mid-operation discards all queued entries and the output result. Inputs presented during reset are ignored.
- Latency: a request accepted at edge E appears with `out_valid = 1` after edge E+1, provided the output register is free or being drained.
- Throughput: 1 result per cycle with `out_ready` held high.
- Total capacity with `out_ready = 0`: `depth + 1` requests (FIFO plus output register).
- `in_ready` depends only on registered `count`; there is no combinational path from `out_ready` to `in_ready`.

## Structure
- Package `rshift_pkg`: `DATA_W = 8`, `SHIFT_W = 3`, and a packed struct `rshift_req_t` {data, bits}.
- Sub-module `rshift_fifo`: depth-parameterised sync FIFO with push/pop, count, full/empty, and registered pointers.
- `rshifter` is instantiated unmodified on the FIFO head. Sticky logic and the output register live in the top level.

## Test plan
- Reset, then push `in_data` 8'hB5, `in_bits` 3 with `out_ready` high. Expect 8'h16 and sticky 1, one cycle after acceptance.
- Corner shifts:
  - 8'hFF shift 0 gives 8'hFF, sticky 0.
  - 8'h80 shift 7 gives 8'h01, sticky 0.
  - 8'h81 shift 7 gives 8'h01, sticky 1.
- Backpressure: hold `out_ready = 0` and push 6 requests back-to-back. Exactly 5 are accepted, and `in_ready` is 0 after the 5th. `out_data` holds the first result unchanged. Then release `out_ready` and expect all 5 results in order on consecutive cycles.
- Full with simultaneous push and pop: with the FIFO at `depth` entries, assert `out_ready` and `in_valid` together. The push is rejected that cycle and accepted the next. The pointers wrap past index 3 correctly, with no loss and no reorder.
- Streaming: push 16 random requests with `out_ready` toggled pseudo-randomly. The scoreboard matches every result and sticky bit against the reference model, in order.
- Mid-stream reset: assert `rst` for 1 cycle with 3 entries queued and `out_valid` high. The next cycle shows `out_valid = 0` and `in_ready = 1`, and no stale result ever emerges.
